// File: rtl/idle_ctrl_pkg.sv
// Shared CPU-wide definitions for the IDLE instruction clock-gating controller.
package idle_ctrl_pkg;

    // Width of the interrupt status / enable vectors (ESTAT.IS / ECFG.LIE).
    localparam int unsigned INT_W = 13;

    // Idle sequencing states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } idle_state_e;

endpackage

// File: rtl/idle_ctrl.sv
// IDLE controller: after an IDLE retires, drains the pipe and bus, requests
// clock gating, and releases it on any enabled pending interrupt (or timeout).
module idle_ctrl #(
    parameter int unsigned INT_W        = idle_ctrl_pkg::INT_W,
    parameter int unsigned DRAIN_STABLE = 4,
    parameter int unsigned IDLE_TIMEOUT = 0
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             idle_commit,
    input  logic             pipe_empty,
    input  logic             bus_idle,
    input  logic [INT_W-1:0] int_vec,
    input  logic [INT_W-1:0] int_en,
    output logic             block_clock,
    output logic             idle_over,
    output logic             stall_fetch,
    output logic             in_idle,
    output logic [31:0]      idle_cnt
);
    import idle_ctrl_pkg::*;

    localparam int unsigned      TMO_W      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic             TMO_EN     = (IDLE_TIMEOUT != 0);
    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(IDLE_TIMEOUT - 1);

    idle_state_e      state, state_nxt;
    logic [3:0]       drain_cnt, drain_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             wake;
    logic             drain_ok;
    logic             tmo_hit;

    // CRMD.IE is deliberately ignored: any enabled pending line ends IDLE.
    assign wake     = |(int_vec & int_en);
    assign drain_ok = pipe_empty & bus_idle;
    assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);

    // Next-state and counter update; wake always outranks drain progress.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = '0;
        tmo_cnt_nxt   = '0;
        case (state)
            RUN: begin
                if (idle_commit) begin
                    state_nxt = wake ? WAKE : DRAIN;
                end
            end
            DRAIN: begin
                if (wake) begin
                    state_nxt = WAKE;
                end else if (drain_ok) begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state_nxt = SLEEP;
                    end else begin
                        drain_cnt_nxt = drain_cnt + 4'd1;
                    end
                end
            end
            SLEEP: begin
                if (wake || tmo_hit) begin
                    state_nxt = WAKE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            WAKE: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State, counters and outputs; outputs are flops decoded from the next
    // state so block_clock reaches the clock gate glitch-free.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            tmo_cnt     <= '0;
            block_clock <= 1'b0;
            idle_over   <= 1'b0;
            stall_fetch <= 1'b0;
            in_idle     <= 1'b0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            block_clock <= (state_nxt == SLEEP);
            idle_over   <= (state_nxt == WAKE);
            stall_fetch <= (state_nxt != RUN);
            in_idle     <= (state_nxt == DRAIN) || (state_nxt == SLEEP);
        end
    end

    // Free-running count of gated cycles; wraps silently.
    always_ff @(posedge aclk) begin
        if (areset) begin
            idle_cnt <= '0;
        end else if (state == SLEEP) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_idle_ctrl.sv
// Scoreboard bench for idle_ctrl: three instances (default, timeout=8,
// drain=1); expected wake records are queued by stimulus, popped on idle_over.
module tb_idle_ctrl;
    import idle_ctrl_pkg::*;

    logic             aclk = 1'b0;
    logic             areset;
    logic [2:0]       commit;
    logic             pipe_empty;
    logic             bus_idle;
    logic [INT_W-1:0] int_vec;
    logic [INT_W-1:0] int_en;
    logic [2:0]       bc, ov, sf, ii;
    logic [31:0]      cnt [3];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb [3][$];
    logic [2:0] ov_d = '0;

    always #5 aclk = ~aclk;

    idle_ctrl #(.INT_W(INT_W), .DRAIN_STABLE(4), .IDLE_TIMEOUT(0)) u_dut (
        .aclk(aclk), .areset(areset), .idle_commit(commit[0]),
        .pipe_empty(pipe_empty), .bus_idle(bus_idle),
        .int_vec(int_vec), .int_en(int_en),
        .block_clock(bc[0]), .idle_over(ov[0]), .stall_fetch(sf[0]),
        .in_idle(ii[0]), .idle_cnt(cnt[0])
    );

    idle_ctrl #(.INT_W(INT_W), .DRAIN_STABLE(4), .IDLE_TIMEOUT(8)) u_tmo (
        .aclk(aclk), .areset(areset), .idle_commit(commit[1]),
        .pipe_empty(pipe_empty), .bus_idle(bus_idle),
        .int_vec(int_vec), .int_en(int_en),
        .block_clock(bc[1]), .idle_over(ov[1]), .stall_fetch(sf[1]),
        .in_idle(ii[1]), .idle_cnt(cnt[1])
    );

    idle_ctrl #(.INT_W(INT_W), .DRAIN_STABLE(1), .IDLE_TIMEOUT(0)) u_ds1 (
        .aclk(aclk), .areset(areset), .idle_commit(commit[2]),
        .pipe_empty(pipe_empty), .bus_idle(bus_idle),
        .int_vec(int_vec), .int_en(int_en),
        .block_clock(bc[2]), .idle_over(ov[2]), .stall_fetch(sf[2]),
        .in_idle(ii[2]), .idle_cnt(cnt[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Monitor: every idle_over pulse must match a queued wake record.
    always @(negedge aclk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (ov[i]) begin
                chk1($sformatf("u%0d_over_single", i), ov_d[i], 1'b0);
                if (sb[i].size() == 0) begin
                    chk1($sformatf("u%0d_unexpected_over", i), ov[i], 1'b0);
                end else begin
                    e = sb[i].pop_front();
                    chk({e.name, "_idle_cnt"}, cnt[i], e.cnt);
                    chk1({e.name, "_bc_low"}, bc[i], 1'b0);
                    chk1({e.name, "_stall"}, sf[i], 1'b1);
                    chk1({e.name, "_in_idle"}, ii[i], 1'b0);
                end
            end
            ov_d[i] = ov[i];
        end
    end

    initial begin
        areset     = 1'b1;
        commit     = '0;
        pipe_empty = 1'b1;
        bus_idle   = 1'b1;
        int_vec    = '0;
        int_en     = 13'h001;
        repeat (2) tick();
        chk1("rst_bc", bc[0], 1'b0);
        chk1("rst_over", ov[0], 1'b0);
        chk1("rst_stall", sf[0], 1'b0);
        chk1("rst_in_idle", ii[0], 1'b0);
        chk("rst_cnt", cnt[0], 32'd0);
        areset = 1'b0;
        tick();

        // Basic: 4-cycle drain, 20 SLEEP cycles, interrupt line 0 wakes.
        commit[0] = 1'b1;
        tick();
        commit[0] = 1'b0;
        chk1("basic_stall", sf[0], 1'b1);
        chk1("basic_in_idle", ii[0], 1'b1);
        repeat (3) tick();
        chk1("basic_bc_pre", bc[0], 1'b0);
        tick();
        chk1("basic_bc_on", bc[0], 1'b1);
        repeat (19) tick();
        chk("basic_cnt19", cnt[0], 32'd19);
        int_vec = 13'h001;
        sb[0].push_back(exp_t'{"basic", 32'd20});
        tick();
        chk1("basic_bc_off", bc[0], 1'b0);
        int_vec = '0;
        tick();
        chk1("basic_stall_drop", sf[0], 1'b0);
        chk1("basic_over_done", ov[0], 1'b0);

        // Masked interrupt keeps SLEEP until its enable is set.
        commit[0] = 1'b1;
        tick();
        commit[0] = 1'b0;
        repeat (4) tick();
        int_vec = 13'h004;
        repeat (5) tick();
        chk1("masked_bc", bc[0], 1'b1);
        chk("masked_cnt", cnt[0], 32'd25);
        int_en = 13'h005;
        sb[0].push_back(exp_t'{"masked", 32'd26});
        tick();
        chk1("masked_bc_off", bc[0], 1'b0);
        tick();
        int_vec = '0;
        int_en  = 13'h001;

        // Drain interruption at drain_cnt==2 restarts the count.
        commit[0] = 1'b1;
        tick();
        commit[0] = 1'b0;
        repeat (2) tick();
        bus_idle = 1'b0;
        tick();
        bus_idle = 1'b1;
        repeat (3) tick();
        chk1("drain_bc_pre", bc[0], 1'b0);
        chk1("drain_in_idle", ii[0], 1'b1);
        tick();
        chk1("drain_bc_on", bc[0], 1'b1);
        int_vec = 13'h001;
        sb[0].push_back(exp_t'{"drain", 32'd27});
        tick();
        chk1("drain_bc_off", bc[0], 1'b0);
        int_vec = '0;
        tick();

        // Early wake: commit with wake high; commit held into WAKE is ignored.
        int_vec   = 13'h001;
        commit[0] = 1'b1;
        sb[0].push_back(exp_t'{"early", 32'd27});
        tick();
        chk1("early_bc", bc[0], 1'b0);
        chk1("early_stall", sf[0], 1'b1);
        chk1("early_in_idle", ii[0], 1'b0);
        tick();
        commit[0] = 1'b0;
        int_vec   = '0;
        chk1("early_commit_ignored", sf[0], 1'b0);

        // Interrupt while draining.
        commit[0] = 1'b1;
        tick();
        commit[0] = 1'b0;
        chk1("dwake_in_idle", ii[0], 1'b1);
        int_vec = 13'h001;
        sb[0].push_back(exp_t'{"dwake", 32'd27});
        tick();
        chk1("dwake_bc", bc[0], 1'b0);
        int_vec = '0;
        tick();

        // Timeout instance: forced wake after exactly 8 SLEEP cycles.
        commit[1] = 1'b1;
        sb[1].push_back(exp_t'{"tmo", 32'd8});
        tick();
        commit[1] = 1'b0;
        repeat (4) tick();
        chk1("tmo_bc_on", bc[1], 1'b1);
        repeat (7) tick();
        chk1("tmo_bc_hold", bc[1], 1'b1);
        chk("tmo_cnt7", cnt[1], 32'd7);
        tick();
        chk1("tmo_bc_off", bc[1], 1'b0);
        tick();

        // DRAIN_STABLE=1: SLEEP right after the first qualifying cycle.
        commit[2] = 1'b1;
        tick();
        commit[2] = 1'b0;
        chk1("ds1_in_idle", ii[2], 1'b1);
        chk1("ds1_bc_pre", bc[2], 1'b0);
        tick();
        chk1("ds1_bc_on", bc[2], 1'b1);
        int_vec = 13'h001;
        sb[2].push_back(exp_t'{"ds1", 32'd1});
        tick();
        chk1("ds1_bc_off", bc[2], 1'b0);
        int_vec = '0;
        tick();

        // Reset mid-SLEEP: back to RUN, no idle_over.
        commit[0] = 1'b1;
        tick();
        commit[0] = 1'b0;
        repeat (4) tick();
        chk1("rst_sleep_bc_on", bc[0], 1'b1);
        repeat (3) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk1("rst_sleep_bc", bc[0], 1'b0);
        chk1("rst_sleep_stall", sf[0], 1'b0);
        chk1("rst_sleep_in_idle", ii[0], 1'b0);
        chk1("rst_sleep_over", ov[0], 1'b0);
        chk("rst_sleep_cnt", cnt[0], 32'd0);
        tick();
        chk1("rst_sleep_no_over", ov[0], 1'b0);

        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_sb_empty", i), 32'(sb[i].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
